// File: rtl/pixel_frame_sink.sv
// pixel_frame_sink: receiving end of the raster pixel stream.
// Buffers (x, y, colour) pixels in a small FIFO, drives the VGA adapter plot
// port, checks raster order/range and reports frame completion.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       upstream pixel handshake
//   in_x, in_y, in_colour   pixel position and colour
//   plot_en                 VGA adapter may take a pixel this cycle
//   plot, vga_x/y/colour    write strobe and pixel to the VGA adapter
//   frame_done              one-cycle pulse when a whole frame has been plotted
//   pixel_count             in-range pixels accepted in current/last frame
//   frame_count             completed frames (wraps)
//   seq_error               sticky out-of-order / out-of-range flag
module pixel_frame_sink #(
   parameter int unsigned SCREEN_W   = 160,
   parameter int unsigned SCREEN_H   = 120,
   parameter int unsigned COLOUR_W   = 24,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          in_x,
   input  logic [7:0]          in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   input  logic                plot_en,
   output logic                plot,
   output logic [7:0]          vga_x,
   output logic [7:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                frame_done,
   output logic [14:0]         pixel_count,
   output logic [7:0]          frame_count,
   output logic                seq_error
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned ENTRY_W = 16 + COLOUR_W;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W:0]     r_wr_ptr;
   logic [PTR_W:0]     r_rd_ptr;

   logic [7:0]          r_ex;
   logic [7:0]          r_ey;
   logic                r_plot;
   logic [7:0]          r_vga_x;
   logic [7:0]          r_vga_y;
   logic [COLOUR_W-1:0] r_vga_colour;
   logic                r_frame_done;
   logic [14:0]         r_pixel_count;
   logic [7:0]          r_frame_count;
   logic                r_seq_error;

   logic                w_empty;
   logic                w_full;
   logic                w_accept;
   logic                w_in_range;
   logic                w_at_last;
   logic                w_at_eol;
   logic                w_push;
   logic                w_pop;
   logic                w_flush_exit;
   logic [ENTRY_W-1:0]  w_head;

   // FIFO status from extended pointers (MSB distinguishes full from empty)
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

   // Full blocks accept even when a pop happens in the same cycle
   assign in_ready   = !reset && !w_full && ((r_state == S_IDLE) || (r_state == S_STREAM));
   assign w_accept   = in_valid && in_ready;
   assign w_in_range = ({1'b0, in_x} < 9'(SCREEN_W)) && ({1'b0, in_y} < 9'(SCREEN_H));
   assign w_at_eol   = (r_ex == 8'(SCREEN_W - 1));
   assign w_at_last  = w_at_eol && (r_ey == 8'(SCREEN_H - 1));
   assign w_push     = w_accept && w_in_range;
   assign w_pop      = !w_empty && plot_en;
   assign w_head     = r_mem[r_rd_ptr[PTR_W-1:0]];

   // Frame is finished once the buffer is drained and the last plot strobe is gone
   assign w_flush_exit = (r_state == S_FLUSH) && w_empty && !r_plot;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_at_last ? S_FLUSH : S_STREAM;
         end
         S_STREAM: begin
            if (w_accept && w_at_last) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_flush_exit) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pixel storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_x, in_y, in_colour};
   end

   // FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Plot port: strobe follows a pop by one cycle, pixel fields hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_plot       <= 1'b0;
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_vga_colour <= '0;
      end else begin
         r_plot <= w_pop;
         if (w_pop) begin
            r_vga_x      <= w_head[ENTRY_W-1 -: 8];
            r_vga_y      <= w_head[ENTRY_W-9 -: 8];
            r_vga_colour <= w_head[COLOUR_W-1:0];
         end
      end
   end

   // Raster position tracking and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex        <= '0;
         r_ey        <= '0;
         r_seq_error <= 1'b0;
      end else if (w_accept) begin
         if (!w_in_range || (in_x != r_ex) || (in_y != r_ey)) r_seq_error <= 1'b1;
         if (w_at_last) begin
            r_ex <= '0;
            r_ey <= '0;
         end else if (w_at_eol) begin
            r_ex <= '0;
            r_ey <= r_ey + 8'd1;
         end else begin
            r_ex <= r_ex + 8'd1;
         end
      end
   end

   // Frame statistics; pixel_count restarts on the first accept of a frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pixel_count <= '0;
         r_frame_count <= '0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= w_flush_exit;
         if (w_flush_exit) r_frame_count <= r_frame_count + 8'd1;
         if (w_accept) begin
            if (r_state == S_IDLE)  r_pixel_count <= w_in_range ? 15'd1 : 15'd0;
            else if (w_in_range)    r_pixel_count <= r_pixel_count + 15'd1;
         end
      end
   end

   assign plot        = r_plot;
   assign vga_x       = r_vga_x;
   assign vga_y       = r_vga_y;
   assign vga_colour  = r_vga_colour;
   assign frame_done  = r_frame_done;
   assign pixel_count = r_pixel_count;
   assign frame_count = r_frame_count;
   assign seq_error   = r_seq_error;

endmodule

// File: tb/tb_pixel_frame_sink.sv
// tb_pixel_frame_sink: directed stimulus with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pixel_frame_sink;

   localparam int W  = 160;
   localparam int H  = 120;
   localparam int CW = 24;

   typedef struct packed {
      logic [7:0]    x;
      logic [7:0]    y;
      logic [CW-1:0] c;
   } pix_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_x = '0;
   logic [7:0]    in_y = '0;
   logic [CW-1:0] in_colour = '0;
   logic          plot_en = 1'b1;
   logic          plot;
   logic [7:0]    vga_x;
   logic [7:0]    vga_y;
   logic [CW-1:0] vga_colour;
   logic          frame_done;
   logic [14:0]   pixel_count;
   logic [7:0]    frame_count;
   logic          seq_error;

   pixel_frame_sink dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
      .plot_en(plot_en), .plot(plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .frame_done(frame_done), .pixel_count(pixel_count),
      .frame_count(frame_count), .seq_error(seq_error)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_plots = 0;
   int n_dones = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   pix_t        q[$];
   logic        m_plot;
   pix_t        m_vga;
   logic        m_done_pulse;
   logic        m_done_phase;
   logic        m_draining;
   logic        m_in_frame;
   logic [7:0]  m_fc;
   logic [14:0] m_pc;
   logic        m_seq;
   int          m_ex;
   int          m_ey;

   always @(posedge clk) begin : model
      logic rdy, acc, inr, was_plot, drain, donep;
      int occ;
      if (reset) begin
         q.delete();
         m_plot = 0; m_vga = '0; m_done_pulse = 0; m_done_phase = 0;
         m_draining = 0; m_in_frame = 0; m_fc = 0; m_pc = 0; m_seq = 0;
         m_ex = 0; m_ey = 0;
      end else begin
         rdy      = (q.size() < 4) && !m_draining && !m_done_phase;
         acc      = in_valid && rdy;
         was_plot = m_plot;
         occ      = q.size();
         drain    = m_draining;
         donep    = m_done_phase;
         if (occ > 0 && plot_en) begin
            m_vga  = q.pop_front();
            m_plot = 1;
         end else begin
            m_plot = 0;
         end
         m_done_pulse = 0;
         if (donep) begin
            m_done_phase = 0;
            m_in_frame   = 0;
         end else if (drain && occ == 0 && !was_plot) begin
            m_draining   = 0;
            m_done_phase = 1;
            m_done_pulse = 1;
            m_fc         = m_fc + 8'd1;
         end
         if (acc) begin
            inr = (int'(in_x) < W) && (int'(in_y) < H);
            if (!inr || int'(in_x) != m_ex || int'(in_y) != m_ey) m_seq = 1;
            if (inr) q.push_back('{x: in_x, y: in_y, c: in_colour});
            if (!m_in_frame) begin
               m_in_frame = 1;
               m_pc = 15'(inr);
            end else begin
               m_pc = m_pc + 15'(inr);
            end
            if (m_ex == W-1 && m_ey == H-1) begin
               m_draining = 1; m_ex = 0; m_ey = 0;
            end else if (m_ex == W-1) begin
               m_ex = 0; m_ey++;
            end else begin
               m_ex++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_plot", plot, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_pixel_count", pixel_count, 0);
         chk("rst_frame_count", frame_count, 0);
         chk("rst_seq_error", seq_error, 0);
         chk("rst_vga", {vga_x, vga_y, vga_colour}, 0);
      end else begin
         chk("in_ready", in_ready, (q.size() < 4) && !m_draining && !m_done_phase);
         chk("plot", plot, m_plot);
         chk("vga_x", vga_x, m_vga.x);
         chk("vga_y", vga_y, m_vga.y);
         chk("vga_colour", vga_colour, m_vga.c);
         chk("frame_done", frame_done, m_done_pulse);
         chk("pixel_count", pixel_count, m_pc);
         chk("frame_count", frame_count, m_fc);
         chk("seq_error", seq_error, m_seq);
         if (plot) n_plots++;
         if (frame_done) n_dones++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int x, input int y, input logic [CW-1:0] c);
      int   n;
      logic rdy;
      in_valid = 1; in_x = 8'(x); in_y = 8'(y); in_colour = c;
      n = 0;
      do begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         n_total++;
         $display("FAIL send_timeout: pixel (%0d,%0d) not accepted in %0d cycles", x, y, n);
      end
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic send_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            send(x, y, {8'(x), 8'(y), 8'h5A});
      in_valid = 0;
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (n_dones == d0 && n < 30) begin
         @(posedge clk); n++;
      end
      #1;
      if (n_dones == d0) begin
         n_total++;
         $display("FAIL frame_done_timeout: no pulse within %0d cycles", n);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int p0, d0;
      #1 reset = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_fcount", frame_count, 0);

      // single pixel latency: accepted at N, plot at N+2
      @(posedge clk); #1;
      send(0, 0, 24'hFFFFFF);
      in_valid = 0;
      @(negedge clk); chk("lat_n1_plot", plot, 0);
      @(negedge clk); chk("lat_n2_plot", plot, 1);
      chk("lat_vga_x", vga_x, 0);
      chk("lat_vga_y", vga_y, 0);
      chk("lat_vga_colour", vga_colour, 24'hFFFFFF);
      idle(3);

      // out-of-order pixel: still plotted, error sticky
      send(5, 0, 24'h123456);
      in_valid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("ooo_plot", plot, 1);
      chk("ooo_vga_x", vga_x, 5);
      chk("ooo_seq_error", seq_error, 1);
      idle(5);
      chk("ooo_sticky", seq_error, 1);

      // out-of-range pixel dropped, count unchanged
      p0 = n_plots;
      send(200, 10, 24'hABCDEF);
      idle(5);
      chk("oor_no_plot", n_plots - p0, 0);
      chk("oor_seq_error", seq_error, 1);
      chk("oor_pixel_count", pixel_count, 2);

      // back-pressure: 4 fit, 5th waits until a pop frees a slot
      plot_en = 0;
      for (int i = 0; i < 4; i++) send(7 + i, 0, 24'h00A000 + 24'(i));
      in_x = 8'd11; in_y = 8'd0; in_colour = 24'h00A004;
      @(negedge clk); chk("bp_full_ready", in_ready, 0);
      @(posedge clk); #1 plot_en = 1;
      @(negedge clk); chk("bp_pop_same_cycle_ready", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready_after_pop", in_ready, 1);
      chk("bp_first_plot", plot, 1);
      chk("bp_first_x", vga_x, 7);
      @(posedge clk); #1 in_valid = 0;
      idle(10);
      chk("bp_pixel_count", pixel_count, 7);

      // full frame after reset
      do_reset();
      p0 = n_plots; d0 = n_dones;
      send_frame();
      wait_done(d0);
      idle(5);
      chk("frame_plots", n_plots - p0, 19200);
      chk("frame_dones", n_dones - d0, 1);
      chk("frame_pixel_count", pixel_count, 19200);
      chk("frame_count_1", frame_count, 1);
      chk("frame_seq_error", seq_error, 0);

      // mid-frame reset then a clean frame
      for (int i = 0; i < 1000; i++) send(i % W, i / W, 24'h0F0F0F);
      d0 = n_dones;
      reset = 1;
      in_valid = 0;
      #1;
      chk("mid_rst_plot", plot, 0);
      chk("mid_rst_fcount", frame_count, 0);
      chk("mid_rst_pcount", pixel_count, 0);
      chk("mid_rst_done", frame_done, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      idle(3);
      chk("mid_rst_no_done", n_dones - d0, 0);
      d0 = n_dones;
      send_frame();
      wait_done(d0);
      idle(3);
      chk("rerun_done", n_dones - d0, 1);
      chk("rerun_frame_count", frame_count, 1);
      chk("rerun_pixel_count", pixel_count, 19200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
